wb_bram_arbiter: RTL and testbench
==================================

Name: wb_bram_arbiter

Overview:
- Two-master Wishbone arbiter and sequencer for the single-port 32-bit block RAM in the bring-up top.
- Master 0 is the QSPI slave WB port; master 1 is a second requester (debug/loader).
- Grants the BRAM round-robin, drives its enable, address, write-enable and data pins, and generates ack/err toward each master.
- Replaces the ad-hoc ack toggle logic in the top level.

Parameters:
- MEM_AW, 9, BRAM word-address width (512 x 32b); byte address bits [MEM_AW+1:2] index the RAM.
- DW, 32, data width; fixed at 32, SEL width is DW/8.

Ports:
- sys_clk  in  1  system clock; all logic on rising edge
- rst_n  in  1  reset, synchronous, active-low
- m0_cyc_i  in  1  master 0 WB cycle
- m0_stb_i  in  1  master 0 strobe
- m0_adr_i  in  32  master 0 byte address
- m0_we_i  in  1  master 0 write
- m0_dat_i  in  32  master 0 write data
- m0_sel_i  in  4  master 0 byte enables
- m0_dat_o  out  32  master 0 read data
- m0_ack_o  out  1  master 0 acknowledge
- m0_err_o  out  1  master 0 error
- m1_cyc_i, m1_stb_i, m1_adr_i, m1_we_i, m1_dat_i, m1_sel_i, m1_dat_o, m1_ack_o, m1_err_o: same as master 0, for master 1
- mem_en_o  out  1  BRAM enable
- mem_we_o  out  4  BRAM byte write enables
- mem_addr_o  out  MEM_AW  BRAM word address
- mem_di_o  out  32  BRAM write data
- mem_do_i  in  32  BRAM read data; valid the cycle after the enabled edge (DO_REG=0)
- grant_o  out  1  currently/last granted master index
- busy_o  out  1  high in any state other than IDLE

Behaviour:
- Request: mX_req = mX_cyc_i & mX_stb_i.
- States:
  - IDLE: no transfer in progress.
  - ACCESS: one cycle; the BRAM operation is issued.
  - RESP: one cycle; ack or err is returned.
- Reset (rst_n low at an edge):
  - state=IDLE, grant=0, last_grant=1, so master 0 wins first contention.
  - All outputs 0: ack, err, dat_o, mem_en, mem_we, mem_addr, mem_di.
  - Reset mid-transfer: no ack or err is delivered; any memory op already enabled is not repeated.
- Arbitration, in IDLE only:
  - One requester: it wins.
  - Both requesting: the master != last_grant wins.
  - The winner is registered into grant and last_grant on the same edge.
  - grant is held until the return to IDLE; requests from the other master wait with no timeout.
- Address check, done in IDLE on the winner's address: out of range if adr[31:MEM_AW+2] != 0 or adr[1:0] != 0.
  - Out of range: IDLE->RESP directly with the error flag set; the BRAM is never enabled.
  - In range: IDLE->ACCESS.
- ACCESS:
  - mem_en_o = granted master's cyc_i.
  - mem_addr_o = adr[MEM_AW+1:2]; mem_di_o = dat_i.
  - mem_we_o = {4{we_i}} & sel_i & {4{cyc_i}}.
  - If cyc_i is low in ACCESS (abort): no memory op, next state IDLE, no ack.
  - Otherwise ACCESS->RESP.
- RESP:
  - Granted master's ack_o = cyc_i & ~error flag; err_o = cyc_i & error flag.
  - dat_o = mem_do_i on a read ack, else 0.
  - Always RESP->IDLE.
- Latency: request sampled at edge e0 -> ACCESS -> ack high in the cycle after e1 -> IDLE after e2. Ack is 2 cycles after request, 1-cycle pulse. Back-to-back transfers from the same master cost 3 cycles each.
- Ungranted master: ack_o=err_o=0 and dat_o=0 at all times.
- Outside ACCESS: mem_en_o=0, mem_we_o=0. mem_addr_o and mem_di_o may hold the last values.
- A master must drop stb or present a new request after ack. stb still high in IDLE is treated as a new request.
- Simultaneous events:
  - A new request arriving in RESP is not seen until IDLE.
  - Both masters requesting continuously yields strict alternation 0,1,0,1.

Test Plan:
- Single write/read, m0: write 0xDEADBEEF to adr 0x010, sel 0xF -> mem_en 1 cycle with mem_addr=4 and mem_we=0xF; m0_ack 2 cycles after the request. Read adr 0x010 -> m0_dat_o=0xDEADBEEF with ack.
- Byte write: m1 writes 0x000000AA with sel=0x1 to adr 0x020 -> mem_we=0x1, mem_addr=8. A read then returns the prior upper bytes with low byte 0xAA.
- Contention: m0 and m1 both request continuously for 4 transfers after reset -> grants 0,1,0,1; each ack is 1 cycle; no cycle has both acks.
- Range error: m0 reads adr 0x0000_0800 (MEM_AW=9), and separately adr 0x002 -> m0_err_o pulses 1 cycle after the request, mem_en stays 0, ack stays 0.
- Abort: m1 drops cyc in ACCESS during a write -> mem_en=0 and mem_we=0, no ack; the next m0 request is served normally.
- Reset mid-transfer: rst_n low during RESP -> all outputs 0 next cycle, state IDLE. After release, m0 and m1 requesting together -> m0 granted first.

Source files
------------

// File: rtl/wb_bram_arbiter.sv
// Two-master Wishbone arbiter for a single-port 32-bit block RAM.
// Round-robin grant in IDLE, one-cycle ACCESS to the BRAM, one-cycle RESP with ack/err.
module wb_bram_arbiter #(
    parameter int MEM_AW = 9,
    parameter int DW     = 32
) (
    input  logic              sys_clk,
    input  logic              rst_n,

    input  logic              m0_cyc_i,
    input  logic              m0_stb_i,
    input  logic [31:0]       m0_adr_i,
    input  logic              m0_we_i,
    input  logic [DW-1:0]     m0_dat_i,
    input  logic [DW/8-1:0]   m0_sel_i,
    output logic [DW-1:0]     m0_dat_o,
    output logic              m0_ack_o,
    output logic              m0_err_o,

    input  logic              m1_cyc_i,
    input  logic              m1_stb_i,
    input  logic [31:0]       m1_adr_i,
    input  logic              m1_we_i,
    input  logic [DW-1:0]     m1_dat_i,
    input  logic [DW/8-1:0]   m1_sel_i,
    output logic [DW-1:0]     m1_dat_o,
    output logic              m1_ack_o,
    output logic              m1_err_o,

    output logic              mem_en_o,
    output logic [DW/8-1:0]   mem_we_o,
    output logic [MEM_AW-1:0] mem_addr_o,
    output logic [DW-1:0]     mem_di_o,
    input  logic [DW-1:0]     mem_do_i,

    output logic              grant_o,
    output logic              busy_o
);

    localparam int SW = DW / 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              grant_q, grant_d;
    logic              last_grant_q, last_grant_d;
    logic              err_q, err_d;
    logic              we_q, we_d;
    logic [MEM_AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0]     mem_di_q, mem_di_d;

    logic              m0_req, m1_req;
    logic              m0_bad, m1_bad;
    logic              winner, win_bad;
    logic              g_cyc, g_we;
    logic [MEM_AW-1:0] g_word;
    logic [DW-1:0]     g_dat;
    logic [SW-1:0]     g_sel;
    logic              in_access, in_resp;
    logic              ack_pend, err_pend;
    logic [DW-1:0]     rd_data;

    assign m0_req = m0_cyc_i & m0_stb_i;
    assign m1_req = m1_cyc_i & m1_stb_i;

    // Word-aligned and inside the RAM, otherwise the transfer ends in err without touching the BRAM
    assign m0_bad = (m0_adr_i[31:MEM_AW+2] != '0) || (m0_adr_i[1:0] != 2'b00);
    assign m1_bad = (m1_adr_i[31:MEM_AW+2] != '0) || (m1_adr_i[1:0] != 2'b00);

    assign winner  = (m0_req & m1_req) ? ~last_grant_q : m1_req;
    assign win_bad = winner ? m1_bad : m0_bad;

    assign g_cyc  = grant_q ? m1_cyc_i : m0_cyc_i;
    assign g_we   = grant_q ? m1_we_i  : m0_we_i;
    assign g_word = grant_q ? m1_adr_i[MEM_AW+1:2] : m0_adr_i[MEM_AW+1:2];
    assign g_dat  = grant_q ? m1_dat_i : m0_dat_i;
    assign g_sel  = grant_q ? m1_sel_i : m0_sel_i;

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        err_d        = err_q;
        we_d         = we_q;
        mem_addr_d   = mem_addr_q;
        mem_di_d     = mem_di_q;
        case (state_q)
            IDLE: begin
                if (m0_req | m1_req) begin
                    grant_d      = winner;
                    last_grant_d = winner;
                    err_d        = win_bad;
                    we_d         = winner ? m1_we_i : m0_we_i;
                    state_d      = win_bad ? RESP : ACCESS;
                end
            end
            ACCESS: begin
                if (g_cyc) begin
                    mem_addr_d = g_word;
                    mem_di_d   = g_dat;
                    state_d    = RESP;
                end else begin
                    state_d = IDLE;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            err_q        <= 1'b0;
            we_q         <= 1'b0;
            mem_addr_q   <= '0;
            mem_di_q     <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            err_q        <= err_d;
            we_q         <= we_d;
            mem_addr_q   <= mem_addr_d;
            mem_di_q     <= mem_di_d;
        end
    end

    assign in_access = (state_q == ACCESS);
    assign in_resp   = (state_q == RESP);

    // Dropping cyc during ACCESS suppresses the BRAM operation in that same cycle
    assign mem_en_o   = in_access & g_cyc;
    assign mem_we_o   = in_access ? ({SW{g_we}} & g_sel & {SW{g_cyc}}) : '0;
    assign mem_addr_o = in_access ? g_word : mem_addr_q;
    assign mem_di_o   = in_access ? g_dat  : mem_di_q;

    assign ack_pend = in_resp & g_cyc & ~err_q;
    assign err_pend = in_resp & g_cyc & err_q;
    assign rd_data  = (ack_pend & ~we_q) ? mem_do_i : '0;

    assign m0_ack_o = ack_pend & ~grant_q;
    assign m1_ack_o = ack_pend & grant_q;
    assign m0_err_o = err_pend & ~grant_q;
    assign m1_err_o = err_pend & grant_q;
    assign m0_dat_o = grant_q ? '0 : rd_data;
    assign m1_dat_o = grant_q ? rd_data : '0;

    assign grant_o = grant_q;
    assign busy_o  = (state_q != IDLE);

endmodule

// File: tb/tb_wb_bram_arbiter.sv
// Directed bench for wb_bram_arbiter with a behavioural 512x32 BRAM (one-cycle read latency).
module tb_wb_bram_arbiter;

    logic        sys_clk;
    logic        rst_n;
    logic        m0_cyc_i, m0_stb_i, m0_we_i;
    logic [31:0] m0_adr_i, m0_dat_i, m0_dat_o;
    logic [3:0]  m0_sel_i;
    logic        m0_ack_o, m0_err_o;
    logic        m1_cyc_i, m1_stb_i, m1_we_i;
    logic [31:0] m1_adr_i, m1_dat_i, m1_dat_o;
    logic [3:0]  m1_sel_i;
    logic        m1_ack_o, m1_err_o;
    logic        mem_en_o;
    logic [3:0]  mem_we_o;
    logic [8:0]  mem_addr_o;
    logic [31:0] mem_di_o;
    logic [31:0] mem_do_i;
    logic        grant_o, busy_o;

    int passCount = 0;
    int checkCount = 0;
    int failCount = 0;

    logic [31:0] memModel [0:511];

    wb_bram_arbiter #(.MEM_AW(9), .DW(32)) dut (
        .sys_clk   (sys_clk),
        .rst_n     (rst_n),
        .m0_cyc_i  (m0_cyc_i),
        .m0_stb_i  (m0_stb_i),
        .m0_adr_i  (m0_adr_i),
        .m0_we_i   (m0_we_i),
        .m0_dat_i  (m0_dat_i),
        .m0_sel_i  (m0_sel_i),
        .m0_dat_o  (m0_dat_o),
        .m0_ack_o  (m0_ack_o),
        .m0_err_o  (m0_err_o),
        .m1_cyc_i  (m1_cyc_i),
        .m1_stb_i  (m1_stb_i),
        .m1_adr_i  (m1_adr_i),
        .m1_we_i   (m1_we_i),
        .m1_dat_i  (m1_dat_i),
        .m1_sel_i  (m1_sel_i),
        .m1_dat_o  (m1_dat_o),
        .m1_ack_o  (m1_ack_o),
        .m1_err_o  (m1_err_o),
        .mem_en_o  (mem_en_o),
        .mem_we_o  (mem_we_o),
        .mem_addr_o(mem_addr_o),
        .mem_di_o  (mem_di_o),
        .mem_do_i  (mem_do_i),
        .grant_o   (grant_o),
        .busy_o    (busy_o)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    // Read-first single-port RAM with byte enables, output valid the cycle after the enabled edge
    always @(posedge sys_clk) begin
        if (mem_en_o) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_we_o[b]) memModel[mem_addr_o][8*b +: 8] <= mem_di_o[8*b +: 8];
            end
            mem_do_i <= memModel[mem_addr_o];
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input int m, input logic we, input logic [31:0] adr,
                                 input logic [31:0] dat, input logic [3:0] sel);
        if (m == 0) begin
            m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_we_i = we;
            m0_adr_i = adr;  m0_dat_i = dat;  m0_sel_i = sel;
        end else begin
            m1_cyc_i = 1'b1; m1_stb_i = 1'b1; m1_we_i = we;
            m1_adr_i = adr;  m1_dat_i = dat;  m1_sel_i = sel;
        end
    endtask

    task automatic releaseMaster(input int m);
        if (m == 0) begin
            m0_cyc_i = 1'b0; m0_stb_i = 1'b0; m0_we_i = 1'b0;
        end else begin
            m1_cyc_i = 1'b0; m1_stb_i = 1'b0; m1_we_i = 1'b0;
        end
    endtask

    // Single in-range transfer from IDLE: ACCESS, RESP, back to IDLE; starts and ends at a negedge
    task automatic runTransfer(input string name, input int m, input logic we, input logic [31:0] adr,
                               input logic [31:0] dat, input logic [3:0] sel,
                               input logic [31:0] expWe, input logic [31:0] expRd);
        logic [31:0] ackMine, ackOther, datMine;
        applyStimulus(m, we, adr, dat, sel);
        @(negedge sys_clk);
        checkOutput({name, "_acc_en"}, 32'(mem_en_o), 32'd1);
        checkOutput({name, "_acc_addr"}, 32'(mem_addr_o), 32'(adr[10:2]));
        checkOutput({name, "_acc_we"}, 32'(mem_we_o), expWe);
        checkOutput({name, "_acc_di"}, mem_di_o, dat);
        checkOutput({name, "_acc_grant"}, 32'(grant_o), 32'(m));
        @(negedge sys_clk);
        ackMine  = (m == 0) ? 32'(m0_ack_o) : 32'(m1_ack_o);
        ackOther = (m == 0) ? 32'(m1_ack_o) : 32'(m0_ack_o);
        datMine  = (m == 0) ? m0_dat_o : m1_dat_o;
        checkOutput({name, "_resp_ack"}, ackMine, 32'd1);
        checkOutput({name, "_resp_other_ack"}, ackOther, 32'd0);
        checkOutput({name, "_resp_dat"}, datMine, expRd);
        checkOutput({name, "_resp_en"}, 32'(mem_en_o), 32'd0);
        @(negedge sys_clk);
        ackMine = (m == 0) ? 32'(m0_ack_o) : 32'(m1_ack_o);
        checkOutput({name, "_idle_ack"}, ackMine, 32'd0);
        checkOutput({name, "_idle_busy"}, 32'(busy_o), 32'd0);
        releaseMaster(m);
    endtask

    task automatic runError(input string name, input logic [31:0] adr);
        applyStimulus(0, 1'b0, adr, 32'h0, 4'hF);
        @(negedge sys_clk);
        checkOutput({name, "_err"}, 32'(m0_err_o), 32'd1);
        checkOutput({name, "_ack"}, 32'(m0_ack_o), 32'd0);
        checkOutput({name, "_en"}, 32'(mem_en_o), 32'd0);
        checkOutput({name, "_busy"}, 32'(busy_o), 32'd1);
        @(negedge sys_clk);
        checkOutput({name, "_err_end"}, 32'(m0_err_o), 32'd0);
        checkOutput({name, "_en_end"}, 32'(mem_en_o), 32'd0);
        checkOutput({name, "_busy_end"}, 32'(busy_o), 32'd0);
        releaseMaster(0);
    endtask

    initial begin
        rst_n = 1'b0;
        m0_cyc_i = 1'b0; m0_stb_i = 1'b0; m0_we_i = 1'b0; m0_adr_i = '0; m0_dat_i = '0; m0_sel_i = '0;
        m1_cyc_i = 1'b0; m1_stb_i = 1'b0; m1_we_i = 1'b0; m1_adr_i = '0; m1_dat_i = '0; m1_sel_i = '0;
        repeat (2) @(negedge sys_clk);

        checkOutput("rst_busy", 32'(busy_o), 32'd0);
        checkOutput("rst_grant", 32'(grant_o), 32'd0);
        checkOutput("rst_acks", {30'd0, m0_ack_o, m1_ack_o}, 32'd0);
        checkOutput("rst_errs", {30'd0, m0_err_o, m1_err_o}, 32'd0);
        checkOutput("rst_m0_dat", m0_dat_o, 32'd0);
        checkOutput("rst_m1_dat", m1_dat_o, 32'd0);
        checkOutput("rst_mem_en_we", {27'd0, mem_en_o, mem_we_o}, 32'd0);
        checkOutput("rst_mem_addr", 32'(mem_addr_o), 32'd0);
        checkOutput("rst_mem_di", mem_di_o, 32'd0);
        rst_n = 1'b1;

        runTransfer("m0_wr", 0, 1'b1, 32'h010, 32'hDEADBEEF, 4'hF, 32'hF, 32'h0);
        runTransfer("m0_rd", 0, 1'b0, 32'h010, 32'h0, 4'hF, 32'h0, 32'hDEADBEEF);
        runTransfer("m1_wr", 1, 1'b1, 32'h020, 32'h11223344, 4'hF, 32'hF, 32'h0);
        runTransfer("m1_bw", 1, 1'b1, 32'h020, 32'h000000AA, 4'h1, 32'h1, 32'h0);
        runTransfer("m1_rd", 1, 1'b0, 32'h020, 32'h0, 4'hF, 32'h0, 32'h112233AA);

        runError("err_hi", 32'h0000_0800);
        runError("err_mis", 32'h0000_0002);

        // m1 abandons its write just after the grant edge
        applyStimulus(1, 1'b1, 32'h030, 32'h12345678, 4'hF);
        @(posedge sys_clk);
        #1;
        releaseMaster(1);
        @(negedge sys_clk);
        checkOutput("abort_en", 32'(mem_en_o), 32'd0);
        checkOutput("abort_we", 32'(mem_we_o), 32'd0);
        checkOutput("abort_busy", 32'(busy_o), 32'd1);
        checkOutput("abort_ack", 32'(m1_ack_o), 32'd0);
        @(negedge sys_clk);
        checkOutput("abort_idle", 32'(busy_o), 32'd0);
        checkOutput("abort_ack_end", 32'(m1_ack_o), 32'd0);
        runTransfer("after_abort", 0, 1'b0, 32'h010, 32'h0, 4'hF, 32'h0, 32'hDEADBEEF);

        // Both masters request continuously after a fresh reset
        rst_n = 1'b0;
        @(negedge sys_clk);
        rst_n = 1'b1;
        applyStimulus(0, 1'b0, 32'h010, 32'h0, 4'hF);
        applyStimulus(1, 1'b0, 32'h020, 32'h0, 4'hF);
        for (int t = 0; t < 4; t++) begin
            @(negedge sys_clk);
            checkOutput($sformatf("cont%0d_grant", t), 32'(grant_o), 32'(t % 2));
            checkOutput($sformatf("cont%0d_en", t), 32'(mem_en_o), 32'd1);
            checkOutput($sformatf("cont%0d_acc_acks", t), {30'd0, m0_ack_o, m1_ack_o}, 32'd0);
            @(negedge sys_clk);
            checkOutput($sformatf("cont%0d_acks", t), {30'd0, m0_ack_o, m1_ack_o},
                        (t % 2 == 0) ? 32'd2 : 32'd1);
            checkOutput($sformatf("cont%0d_m0_dat", t), m0_dat_o, (t % 2 == 0) ? 32'hDEADBEEF : 32'h0);
            checkOutput($sformatf("cont%0d_m1_dat", t), m1_dat_o, (t % 2 == 1) ? 32'h112233AA : 32'h0);
            @(negedge sys_clk);
            checkOutput($sformatf("cont%0d_idle_acks", t), {30'd0, m0_ack_o, m1_ack_o}, 32'd0);
            checkOutput($sformatf("cont%0d_idle_busy", t), 32'(busy_o), 32'd0);
        end
        releaseMaster(0);
        releaseMaster(1);

        // Reset lands while the write is in RESP
        applyStimulus(0, 1'b1, 32'h040, 32'h55AA55AA, 4'hF);
        @(negedge sys_clk);
        checkOutput("rmid_acc_en", 32'(mem_en_o), 32'd1);
        @(negedge sys_clk);
        checkOutput("rmid_resp_ack", 32'(m0_ack_o), 32'd1);
        checkOutput("rmid_resp_addr", 32'(mem_addr_o), 32'h10);
        checkOutput("rmid_resp_di", mem_di_o, 32'h55AA55AA);
        rst_n = 1'b0;
        @(negedge sys_clk);
        checkOutput("rmid_ack", 32'(m0_ack_o), 32'd0);
        checkOutput("rmid_err", 32'(m0_err_o), 32'd0);
        checkOutput("rmid_en", 32'(mem_en_o), 32'd0);
        checkOutput("rmid_addr", 32'(mem_addr_o), 32'd0);
        checkOutput("rmid_di", mem_di_o, 32'd0);
        checkOutput("rmid_busy", 32'(busy_o), 32'd0);
        rst_n = 1'b1;
        applyStimulus(0, 1'b0, 32'h010, 32'h0, 4'hF);
        applyStimulus(1, 1'b0, 32'h020, 32'h0, 4'hF);
        @(negedge sys_clk);
        checkOutput("rmid_first_grant", 32'(grant_o), 32'd0);
        checkOutput("rmid_first_addr", 32'(mem_addr_o), 32'h4);
        @(negedge sys_clk);
        checkOutput("rmid_first_acks", {30'd0, m0_ack_o, m1_ack_o}, 32'd2);
        checkOutput("rmid_first_dat", m0_dat_o, 32'hDEADBEEF);
        @(negedge sys_clk);
        releaseMaster(0);
        releaseMaster(1);
        repeat (2) @(negedge sys_clk);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
